codec_result_reader: RTL and testbench

//  Host-side consumer for the arithmetic_codec result interface (resultReady/readSuccess/validOutputBytes/out).

---
 rtl/codec_result_reader.sv | 140 ++++++++++++++
 tb/tb_codec_result_reader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_result_reader.sv
// codec_result_reader
//   Host-side consumer for the arithmetic codec result interface. Each pending
//   result word (0..4 valid bytes) is captured in a single cycle, unpacked
//   byte0-first into a byte FIFO, and acknowledged with a one-cycle readSuccess
//   pulse. The FIFO drains as a valid/ready byte stream.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   resultReady       codec has a result word pending
//   validOutputBytes  valid byte count of resultWord (values above 4 clamp to 4)
//   resultWord        byte0 = [7:0] ... byte3 = [31:24]
//   readSuccess       one-cycle acknowledge of the captured word
//   byteOut/byteValid FIFO head byte / FIFO not empty
//   byteReady         sink accepts byteOut when byteValid && byteReady
//   fifoLevel         FIFO occupancy
//   byteCount         total bytes pushed since reset (wrapping)
//   protocolErr       sticky: an accepted word reported more than 4 bytes
module codec_result_reader #(
    parameter int FIFO_DEPTH  = 16,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          resultReady,
    input  logic [2:0]                    validOutputBytes,
    input  logic [31:0]                   resultWord,
    output logic                          readSuccess,
    output logic [7:0]                    byteOut,
    output logic                          byteValid,
    input  logic                          byteReady,
    output logic [$clog2(FIFO_DEPTH):0]   fifoLevel,
    output logic [COUNT_WIDTH-1:0]        byteCount,
    output logic                          protocolErr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        WAIT_LOW
    } state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   err_q, err_d;
    logic                   rs_q, rs_d;
    logic [7:0]             head_q, head_d;
    logic [7:0]             mem_q [FIFO_DEPTH];
    logic [7:0]             mem_d [FIFO_DEPTH];

    logic [2:0]             n_eff;
    logic [2:0]             push_n;
    logic [LVL_W-1:0]       free_slots;
    logic                   accept;
    logic                   pop;

    always_comb begin
        n_eff      = (validOutputBytes > 3'd4) ? 3'd4 : validOutputBytes;
        // Space check uses the registered level only; a same-cycle pop is not credited.
        free_slots = LVL_W'(FIFO_DEPTH) - level_q;
        pop        = (level_q != '0) && byteReady;
        accept     = (state_q == IDLE) && resultReady && (free_slots >= LVL_W'(n_eff));
        push_n     = accept ? n_eff : 3'd0;

        state_d = state_q;
        case (state_q)
            IDLE:     if (accept) state_d = ACK;
            ACK:      state_d = WAIT_LOW;
            // Hold off until the codec withdraws the word to avoid recapturing it.
            WAIT_LOW: if (!resultReady) state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        // The pulse is registered from the ACK state, so a reset while in ACK suppresses it.
        rs_d = (state_q == ACK);

        mem_d = mem_q;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < push_n) begin
                mem_d[wr_ptr_q + PTR_W'(i)] = resultWord[8*i +: 8];
            end
        end

        wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        level_d  = level_q + LVL_W'(push_n) - LVL_W'(pop);
        // Head is taken from the post-update array so a byte pushed into an empty
        // (or just-emptied) FIFO appears the cycle after the push; on empty it holds.
        head_d   = (level_d != '0) ? mem_d[rd_ptr_d] : head_q;
        count_d  = count_q + COUNT_WIDTH'(push_n);
        err_d    = err_q | (accept && (validOutputBytes > 3'd4));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            rs_q     <= 1'b0;
            head_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            count_q  <= count_d;
            err_q    <= err_d;
            rs_q     <= rs_d;
            head_q   <= head_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (int'(level_q) + int'(push_n) <= FIFO_DEPTH);
            assert (level_q >= LVL_W'(pop));
        end
    end

    assign readSuccess = rs_q;
    assign byteOut     = head_q;
    assign byteValid   = (level_q != '0);
    assign fifoLevel   = level_q;
    assign byteCount   = count_q;
    assign protocolErr = err_q;

endmodule

// File: tb/tb_codec_result_reader.sv
module tb_codec_result_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        resultReady;
    logic [2:0]  validOutputBytes;
    logic [31:0] resultWord;
    logic        readSuccess;
    logic [7:0]  byteOut;
    logic        byteValid;
    logic        byteReady;
    logic [4:0]  fifoLevel;
    logic [31:0] byteCount;
    logic        protocolErr;

    codec_result_reader #(.FIFO_DEPTH(16), .COUNT_WIDTH(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .resultReady      (resultReady),
        .validOutputBytes (validOutputBytes),
        .resultWord       (resultWord),
        .readSuccess      (readSuccess),
        .byteOut          (byteOut),
        .byteValid        (byteValid),
        .byteReady        (byteReady),
        .fifoLevel        (fifoLevel),
        .byteCount        (byteCount),
        .protocolErr      (protocolErr)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] exp_count = 0;
    bit          exp_err = 0;
    int          acks_exp = 0;
    int          rs_cnt = 0;
    bit          hold_ready = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sink: random backpressure unless held off.
    initial begin
        byteReady = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            byteReady = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: count acks and compare every accepted byte against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (readSuccess) rs_cnt++;
            if (byteValid && byteReady) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL byte_extra: got %0h expected no byte", byteOut);
                end else begin
                    check("byte_out", {56'd0, byteOut}, {56'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // Reference model: a word contributes min(vob,4) bytes, LSB first.
    task automatic model_push(input logic [2:0] v, input logic [31:0] w);
        int n;
        n = (v > 3'd4) ? 4 : int'(v);
        for (int i = 0; i < n; i++) exp_q.push_back(w[8*i +: 8]);
        exp_count += 32'(n);
        if (v > 3'd4) exp_err = 1'b1;
        acks_exp++;
    endtask

    task automatic present(input logic [2:0] v, input logic [31:0] w);
        model_push(v, w);
        @(posedge clk);
        #1;
        resultReady      = 1'b1;
        validOutputBytes = v;
        resultWord       = w;
    endtask

    task automatic wait_ack();
        bit got;
        got = 1'b0;
        for (int k = 0; k < 1000 && !got; k++) begin
            @(negedge clk);
            if (readSuccess) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no readSuccess expected one within 1000 cycles");
        end
    endtask

    task automatic drop(input int extra);
        repeat (extra) @(posedge clk);
        @(posedge clk);
        #1;
        resultReady      = 1'b0;
        validOutputBytes = 3'($urandom);
        resultWord       = $urandom;
    endtask

    task automatic send_word(input logic [2:0] v, input logic [31:0] w);
        present(v, w);
        wait_ack();
        drop(0);
    endtask

    task automatic drain();
        for (int k = 0; k < 2000 && (exp_q.size() != 0 || byteValid); k++) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        resultReady      = 1'b0;
        validOutputBytes = 3'd0;
        resultWord       = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_readSuccess", readSuccess, 0);
        check("rst_byteValid",   byteValid,   0);
        check("rst_byteOut",     byteOut,     0);
        check("rst_fifoLevel",   fifoLevel,   0);
        check("rst_byteCount",   byteCount,   0);
        check("rst_protocolErr", protocolErr, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single 4-byte word.
        hold_ready = 1'b0;
        send_word(3'd4, 32'h44332211);
        check("t1_byteCount", byteCount, 4);
        drain();
        check("t1_acks", rs_cnt, acks_exp);

        // Mixed lengths including an empty word.
        send_word(3'd1, $urandom);
        send_word(3'd3, $urandom);
        send_word(3'd0, $urandom);
        send_word(3'd2, $urandom);
        check("t2_byteCount", byteCount, 10);
        drain();
        check("t2_acks", rs_cnt, acks_exp);

        // Backpressure: fill the FIFO, the fifth word must stall.
        hold_ready = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 4; i++) send_word(3'd4, $urandom);
        check("t3_level_full", fifoLevel, 16);
        present(3'd4, $urandom);
        repeat (10) @(negedge clk);
        check("t3_no_ack_full", rs_cnt, acks_exp - 1);
        check("t3_level_held", fifoLevel, 16);
        hold_ready = 1'b0;
        wait_ack();
        drop(0);
        drain();
        check("t3_acks", rs_cnt, acks_exp);

        // Request held high after the ack: single capture only.
        present(3'd2, $urandom);
        wait_ack();
        drop(5);
        repeat (3) @(negedge clk);
        check("t4_single_capture", rs_cnt, acks_exp);
        send_word(3'd3, $urandom);
        drain();
        check("t4_acks", rs_cnt, acks_exp);

        // Oversized length clamps to 4 and flags the sticky error.
        check("t5_err_before", protocolErr, 0);
        send_word(3'd7, 32'hDDCCBBAA);
        check("t5_err_set", protocolErr, 1);
        drain();
        send_word(3'd1, $urandom);
        send_word(3'd2, $urandom);
        drain();
        check("t5_err_sticky", protocolErr, 1);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send_word(3'($urandom_range(0, 7)), $urandom);
        end
        drain();
        check("rand_byteCount", byteCount, exp_count);
        check("rand_protocolErr", protocolErr, exp_err);
        check("rand_acks", rs_cnt, acks_exp);

        // Reset while in ACK with 9 bytes queued.
        hold_ready = 1'b1;
        repeat (2) @(posedge clk);
        send_word(3'd4, $urandom);
        send_word(3'd4, $urandom);
        @(posedge clk);
        #1;
        resultReady      = 1'b1;
        validOutputBytes = 3'd1;
        resultWord       = $urandom;
        @(posedge clk);
        #1;
        check("t6_level_before", fifoLevel, 9);
        rst = 1'b1;
        exp_q.delete();
        exp_count = 0;
        exp_err   = 1'b0;
        acks_exp  = 0;
        @(negedge clk);
        resultReady = 1'b0;
        check("t6_readSuccess", readSuccess, 0);
        check("t6_byteValid",   byteValid,   0);
        check("t6_byteOut",     byteOut,     0);
        check("t6_fifoLevel",   fifoLevel,   0);
        check("t6_byteCount",   byteCount,   0);
        check("t6_protocolErr", protocolErr, 0);
        rs_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst        = 1'b0;
        hold_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_no_pulse", rs_cnt, 0);
        send_word(3'd3, $urandom);
        drain();
        check("t6_count_after", byteCount, 3);
        check("t6_acks_after", rs_cnt, acks_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
